tiny_host_ctrl: RTL and testbench

Host-side sequencer for the tiny pairing core. It bridges a 32-bit valid/ready host interface to the core's 198-bit RAM access port (sel/addr/w/data/out). It serialises operand loads and result reads, and owns the start/finish sequencing of a pairing run. Only this block drives the core's reset and RAM port.

---
 rtl/tiny_host_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_tiny_host_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tiny_host_ctrl.sv
// -----------------------------------------------------------------------------
// tiny_host_ctrl
//
// Host-side sequencer for the tiny pairing core. It converts a 32-bit
// valid/ready host stream into whole-element accesses on the core's 198-bit
// RAM port, and runs the core's start/finish handshake. This block is the only
// driver of the core's reset and RAM port.
//
// Host command beats (taken in IDLE; host_addr is latched on the command beat):
//   WRITE (0) : this beat plus NB-1 more data beats, least-significant word
//               first, then one core RAM write
//   READ  (1) : one core RAM read, returned as NB rsp beats, LS word first
//   START (2) : pulse the core reset, then wait for core_done or timeout
//   3         : reserved; the beat is consumed and nothing happens
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   host_valid/ready     host command/data beat handshake
//   host_cmd/addr/wdata  command, core RAM address, write data beat
//   rsp_valid/ready      read response beat handshake
//   rsp_data             read response beat (held while stalled)
//   busy                 high in every state except IDLE
//   run_done, run_err    sticky run status, cleared by the next START
//   core_reset           core reset; its falling edge starts a run
//   core_sel             1 = host owns the core RAM port, 0 = core owns it
//   core_addr/w/data     core RAM address, write enable, write data
//   core_out             core RAM read data, one cycle after the address
//   core_done            core finished its computation
//
// Latencies (counted in rising edges after the edge that takes the command
// beat): the core write is driven for the cycle after the last WRITE beat,
// rsp_valid rises on the 2nd edge after a READ beat, and core_reset falls on
// the edge that ends the single KICK cycle following a START beat.
// -----------------------------------------------------------------------------
module tiny_host_ctrl #(
   parameter int HW  = 32,
   parameter int DW  = 198,
   parameter int AW  = 7,
   parameter int NB  = (DW + HW - 1) / HW,
   parameter int TMO = 1048576
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          host_valid,
   output logic          host_ready,
   input  logic [1:0]    host_cmd,
   input  logic [AW-1:0] host_addr,
   input  logic [HW-1:0] host_wdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [HW-1:0] rsp_data,
   output logic          busy,
   output logic          run_done,
   output logic          run_err,
   output logic          core_reset,
   output logic          core_sel,
   output logic [AW-1:0] core_addr,
   output logic          core_w,
   output logic [DW-1:0] core_data,
   input  logic [DW-1:0] core_out,
   input  logic          core_done
);

   localparam int BUFW = NB * HW;
   localparam int BW   = $clog2(NB + 1);
   localparam int CW   = (TMO > 1) ? $clog2(TMO) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_WR, S_RD, S_CAP, S_SEND, S_KICK, S_RUN
   } state_t;

   typedef enum logic [1:0] {
      CMD_WRITE = 2'd0,
      CMD_READ  = 2'd1,
      CMD_START = 2'd2,
      CMD_RSVD  = 2'd3
   } cmd_t;

   state_t          state_q;
   logic [BW-1:0]   beat_q;
   logic [CW-1:0]   tmo_q;
   logic [BUFW-1:0] buf_q;

   logic            host_ready_q, rsp_valid_q, busy_q, run_done_q, run_err_q;
   logic            core_reset_q, core_sel_q, core_w_q;
   logic [HW-1:0]   rsp_data_q;
   logic [AW-1:0]   core_addr_q;
   logic [DW-1:0]   core_data_q;

   logic            host_fire, rsp_fire, last_beat;
   logic [BUFW-1:0] buf_wr, out_ext;

   assign host_fire = host_valid & host_ready_q;
   assign rsp_fire  = rsp_valid_q & rsp_ready;
   assign last_beat = (beat_q == BW'(NB - 1));

   // The read element is zero-extended to whole beats, so the unused top bits
   // of the last response word always read as 0.
   assign out_ext = {{(BUFW - DW){1'b0}}, core_out};

   // Shift buffer with the current beat merged in at word beat_q. Bits of the
   // last word above DW are kept here but never reach core_data.
   // NOTE: every signal written in always_comb gets a full default first, so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      buf_wr = buf_q;
      buf_wr[int'(beat_q) * HW +: HW] = host_wdata;
   end

   // NOTE: state and registered outputs use non-blocking assignments so every
   // register samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: buf_q is a pure data buffer and is deliberately not reset; it
         // is always fully written before any of its contents are used.
         state_q      <= S_IDLE;
         beat_q       <= '0;
         tmo_q        <= '0;
         host_ready_q <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
         busy_q       <= 1'b0;
         run_done_q   <= 1'b0;
         run_err_q    <= 1'b0;
         core_reset_q <= 1'b1;
         core_sel_q   <= 1'b1;
         core_addr_q  <= '0;
         core_w_q     <= 1'b0;
         core_data_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               host_ready_q <= 1'b1;
               if (host_fire) begin
                  core_addr_q <= host_addr;
                  case (cmd_t'(host_cmd))
                     CMD_WRITE: begin
                        buf_q   <= buf_wr;      // beat_q is 0 here: word 0
                        beat_q  <= BW'(1);
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                     end
                     CMD_READ: begin
                        host_ready_q <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= S_RD;
                     end
                     CMD_START: begin
                        host_ready_q <= 1'b0;
                        busy_q       <= 1'b1;
                        core_sel_q   <= 1'b0;   // hand the RAM to the core
                        state_q      <= S_KICK;
                     end
                     default: ;                 // reserved: consumed, no action
                  endcase
               end
            end

            S_LOAD: begin
               if (host_fire) begin
                  buf_q <= buf_wr;
                  if (last_beat) begin
                     beat_q       <= '0;
                     host_ready_q <= 1'b0;
                     core_w_q     <= 1'b1;
                     core_data_q  <= buf_wr[DW-1:0];
                     state_q      <= S_WR;
                  end else begin
                     beat_q <= beat_q + 1'b1;
                  end
               end
            end

            S_WR: begin
               core_w_q     <= 1'b0;
               host_ready_q <= 1'b1;
               busy_q       <= 1'b0;
               state_q      <= S_IDLE;
            end

            // The address is presented during RD; the RAM returns the data
            // one cycle later, during CAP.
            S_RD: state_q <= S_CAP;

            S_CAP: begin
               buf_q       <= out_ext;
               rsp_data_q  <= out_ext[HW-1:0];
               rsp_valid_q <= 1'b1;
               beat_q      <= '0;
               state_q     <= S_SEND;
            end

            S_SEND: begin
               if (rsp_fire) begin
                  if (last_beat) begin
                     rsp_valid_q  <= 1'b0;
                     beat_q       <= '0;
                     host_ready_q <= 1'b1;
                     busy_q       <= 1'b0;
                     state_q      <= S_IDLE;
                  end else begin
                     beat_q     <= beat_q + 1'b1;
                     rsp_data_q <= buf_q[(int'(beat_q) + 1) * HW +: HW];
                  end
               end
            end

            S_KICK: begin
               core_reset_q <= 1'b0;
               run_done_q   <= 1'b0;
               run_err_q    <= 1'b0;
               tmo_q        <= '0;
               state_q      <= S_RUN;
            end

            S_RUN: begin
               if (core_done || tmo_q == CW'(TMO - 1)) begin
                  // done wins over a timeout expiring in the same cycle
                  run_done_q   <= core_done;
                  run_err_q    <= ~core_done;
                  core_reset_q <= 1'b1;
                  core_sel_q   <= 1'b1;
                  host_ready_q <= 1'b1;
                  busy_q       <= 1'b0;
                  state_q      <= S_IDLE;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign host_ready = host_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = rsp_data_q;
   assign busy       = busy_q;
   assign run_done   = run_done_q;
   assign run_err    = run_err_q;
   assign core_reset = core_reset_q;
   assign core_sel   = core_sel_q;
   assign core_addr  = core_addr_q;
   assign core_w     = core_w_q;
   assign core_data  = core_data_q;

endmodule

// File: tb/tb_tiny_host_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tiny_host_ctrl
//
// Directed bench for tiny_host_ctrl. u_dut uses the default parameters and is
// attached to a small core RAM model; u_tmo has TMO=16 and core_done tied low
// to exercise the run timeout. Inputs change and outputs are sampled on the
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_tiny_host_ctrl;

   localparam int HW = 32;
   localparam int DW = 198;
   localparam int AW = 7;
   localparam int NB = 7;

   localparam logic [DW-1:0] ELEM_A = 198'h115a25886512165251569195908560596a6695612620504191;
   localparam logic [DW-1:0] ELEM_B = 198'h1559546442405a181195655549614540592955a15a26984015;

   logic          clk = 1'b0;
   logic          reset;
   logic          host_valid, rsp_ready, core_done;
   logic [1:0]    host_cmd;
   logic [AW-1:0] host_addr;
   logic [HW-1:0] host_wdata;
   logic          host_ready, rsp_valid, busy, run_done, run_err;
   logic          core_reset, core_sel, core_w;
   logic [HW-1:0] rsp_data;
   logic [AW-1:0] core_addr;
   logic [DW-1:0] core_data, core_out;

   logic          t_valid;
   logic [1:0]    t_cmd;
   logic          t_host_ready, t_rsp_valid, t_busy, t_run_done, t_run_err;
   logic          t_core_reset, t_core_sel, t_core_w;
   logic [HW-1:0] t_rsp_data;
   logic [AW-1:0] t_core_addr;
   logic [DW-1:0] t_core_data;

   logic [DW-1:0] mem [2**AW];
   int            wr_count = 0;
   int            errors   = 0;
   int            checks   = 0;

   always #5 clk = ~clk;

   tiny_host_ctrl u_dut (
      .clk(clk), .reset(reset),
      .host_valid(host_valid), .host_ready(host_ready), .host_cmd(host_cmd),
      .host_addr(host_addr), .host_wdata(host_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .busy(busy), .run_done(run_done), .run_err(run_err),
      .core_reset(core_reset), .core_sel(core_sel), .core_addr(core_addr),
      .core_w(core_w), .core_data(core_data), .core_out(core_out),
      .core_done(core_done)
   );

   tiny_host_ctrl #(.TMO(16)) u_tmo (
      .clk(clk), .reset(reset),
      .host_valid(t_valid), .host_ready(t_host_ready), .host_cmd(t_cmd),
      .host_addr('0), .host_wdata('0),
      .rsp_valid(t_rsp_valid), .rsp_ready(1'b1), .rsp_data(t_rsp_data),
      .busy(t_busy), .run_done(t_run_done), .run_err(t_run_err),
      .core_reset(t_core_reset), .core_sel(t_core_sel), .core_addr(t_core_addr),
      .core_w(t_core_w), .core_data(t_core_data), .core_out('0),
      .core_done(1'b0)
   );

   // Core RAM model: host-side write when selected, 1-cycle synchronous read.
   always @(posedge clk) begin
      if (core_sel === 1'b1 && core_w === 1'b1) mem[core_addr] <= core_data;
      core_out <= mem[core_addr];
      if (core_w === 1'b1) wr_count <= wr_count + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals();
      check("rst_host_ready", host_ready, 0);
      check("rst_rsp_valid",  rsp_valid,  0);
      check("rst_rsp_data",   rsp_data,   0);
      check("rst_busy",       busy,       0);
      check("rst_run_done",   run_done,   0);
      check("rst_run_err",    run_err,    0);
      check("rst_core_reset", core_reset, 1);
      check("rst_core_sel",   core_sel,   1);
      check("rst_core_addr",  core_addr,  0);
      check("rst_core_w",     core_w,     0);
      check("rst_core_data",  core_data,  0);
   endtask

   // One host beat; called and returns on a falling edge. On return the beat
   // has been taken by the rising edge just before.
   task automatic beat(input logic [1:0] c, input logic [AW-1:0] a, input logic [HW-1:0] d);
      int n;
      n = 0;
      host_valid = 1'b1; host_cmd = c; host_addr = a; host_wdata = d;
      while (host_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("beat_accept", host_ready, 1);
      @(negedge clk);
      host_valid = 1'b0;
   endtask

   task automatic write_elem(input logic [AW-1:0] a, input logic [DW-1:0] val,
                             input int gap, input bit poison);
      logic [NB*HW-1:0] w;
      logic [HW-1:0]    word;
      int               base;
      base = wr_count;
      w = '0;
      w[DW-1:0] = val;
      for (int k = 0; k < NB; k++) begin
         word = w[k*HW +: HW];
         if (k == NB - 1 && poison) word[31:6] = '1;
         // data beats carry a READ command and a bogus address; both ignored
         beat((k == 0) ? 2'd0 : 2'd1, (k == 0) ? a : 7'h7f, word);
         if (k < NB - 1) repeat (gap) @(negedge clk);
      end
      check("wr_core_w",    core_w,    1);
      check("wr_core_addr", core_addr, a);
      check("wr_core_data", core_data, val);
      @(negedge clk);
      check("wr_core_w_off", core_w,     0);
      check("wr_idle_ready", host_ready, 1);
      check("wr_once",       wr_count,   base + 1);
   endtask

   task automatic read_elem(input logic [AW-1:0] a, input bit lat, input int stall_at,
                            output logic [NB*HW-1:0] v);
      logic [NB*HW-1:0] acc;
      logic [HW-1:0]    held;
      int               k, n, stall;
      acc = '0; k = 0; n = 0; stall = stall_at;
      rsp_ready = 1'b1;
      beat(2'd1, a, '0);
      if (lat) begin
         check("rd_addr",     core_addr,  a);
         check("rd_busy",     busy,       1);
         check("rd_lat0",     rsp_valid,  0);
         @(negedge clk);
         check("rd_lat1",     rsp_valid,  0);
         @(negedge clk);
         check("rd_lat2",     rsp_valid,  1);
      end
      while (k < NB && n < 100) begin
         if (rsp_valid === 1'b1) begin
            if (k == stall) begin
               held = rsp_data;
               rsp_ready = 1'b0;
               for (int i = 0; i < 5; i++) begin
                  @(negedge clk);
                  check("bp_data_stable", rsp_data,   held);
                  check("bp_valid_held",  rsp_valid,  1);
                  check("bp_host_ready",  host_ready, 0);
               end
               rsp_ready = 1'b1;
               stall = -1;
            end
            acc[k*HW +: HW] = rsp_data;
            k++;
         end
         @(negedge clk);
         n++;
      end
      check("rd_beats",    k,         NB);
      check("rd_no_extra", rsp_valid, 0);
      check("rd_idle",     busy,      0);
      v = acc;
   endtask

   initial begin
      logic [NB*HW-1:0] v, exp_a, exp_b;
      int               base;
      exp_a = '0; exp_a[DW-1:0] = ELEM_A;
      exp_b = '0; exp_b[DW-1:0] = ELEM_B;

      reset = 1'b1; host_valid = 1'b0; host_cmd = '0; host_addr = '0;
      host_wdata = '0; rsp_ready = 1'b1; core_done = 1'b0;
      t_valid = 1'b0; t_cmd = '0;

      // reset values after the first edge with reset high
      @(negedge clk);
      chk_reset_vals();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("idle_ready", host_ready, 1);

      // write then read
      write_elem(7'd0, ELEM_A, 0, 1'b0);
      read_elem(7'd0, 1'b1, -1, v);
      check("rd_a",       v,             exp_a);
      check("rd_a_word6", v[223:192],    32'h00000011);

      // backpressure mid-element
      read_elem(7'd0, 1'b0, 3, v);
      check("bp_a", v, exp_a);

      // write with long gaps and junk in the unused bits of the last beat
      write_elem(7'd3, ELEM_B, 10, 1'b1);
      read_elem(7'd3, 1'b0, -1, v);
      check("rd_b", v, exp_b);
      read_elem(7'd0, 1'b0, -1, v);
      check("rd_a_kept", v, exp_a);

      // start and done; a WRITE is offered throughout the run
      base = wr_count;
      beat(2'd2, 7'd0, '0);
      check("kick_core_reset", core_reset, 1);
      check("kick_core_sel",   core_sel,   0);
      check("kick_busy",       busy,       1);
      check("kick_ready",      host_ready, 0);
      @(negedge clk);
      check("run_core_reset",  core_reset, 0);
      check("run_core_sel",    core_sel,   0);
      host_valid = 1'b1; host_cmd = 2'd0; host_addr = 7'd5; host_wdata = 32'hdeadbeef;
      for (int i = 0; i < 48; i++) begin
         @(negedge clk);
         check("run_ready_low", host_ready, 0);
         check("run_reset_low", core_reset, 0);
         check("run_sel_low",   core_sel,   0);
      end
      host_valid = 1'b0;
      core_done = 1'b1;
      @(negedge clk);
      core_done = 1'b0;
      check("done_run_done",   run_done,   1);
      check("done_run_err",    run_err,    0);
      check("done_busy",       busy,       0);
      check("done_core_sel",   core_sel,   1);
      check("done_core_reset", core_reset, 1);
      check("done_ready",      host_ready, 1);
      check("done_no_write",   wr_count,   base);
      check("done_no_rsp",     rsp_valid,  0);

      // next START clears the sticky done flag
      beat(2'd2, 7'd0, '0);
      check("kick2_done_kept", run_done, 1);
      @(negedge clk);
      check("run2_done_clr",   run_done, 0);
      core_done = 1'b1;
      @(negedge clk);
      core_done = 1'b0;
      check("done2_run_done",  run_done, 1);

      // timeout on the TMO=16 instance
      check("tmo_idle_ready", t_host_ready, 1);
      t_valid = 1'b1; t_cmd = 2'd2;
      @(negedge clk);
      t_valid = 1'b0;
      check("tmo_kick_reset", t_core_reset, 1);
      check("tmo_kick_sel",   t_core_sel,   0);
      repeat (16) @(negedge clk);
      check("tmo_run16_busy", t_busy,    1);
      check("tmo_run16_err",  t_run_err, 0);
      @(negedge clk);
      check("tmo_err",        t_run_err,    1);
      check("tmo_done",       t_run_done,   0);
      check("tmo_busy",       t_busy,       0);
      check("tmo_ready",      t_host_ready, 1);
      check("tmo_core_sel",   t_core_sel,   1);
      check("tmo_core_reset", t_core_reset, 1);

      // reset after 4 WRITE beats: partial element dropped
      base = wr_count;
      for (int k = 0; k < 4; k++) beat((k == 0) ? 2'd0 : 2'd1, 7'd0, exp_b[k*HW +: HW]);
      reset = 1'b1;
      @(negedge clk);
      chk_reset_vals();
      check("rst_no_write", wr_count, base);
      reset = 1'b0;
      @(negedge clk);
      read_elem(7'd0, 1'b0, -1, v);
      check("rst_old_a", v, exp_a);
      check("rst_no_write_end", wr_count, base);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
